// File: rtl/clk_div_multi_if.sv
// Control/config and output bundle for the multi-channel clock/tick generator.
interface clk_div_multi_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 27,
    parameter int unsigned CHW = 2
);
    logic [NCH-1:0] en;
    logic           sync;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]   cfg_div;
    logic           cfg_mode;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    // Driver side: enables, sync and configuration writes
    modport master (
        output en, sync, cfg_we, cfg_ch, cfg_div, cfg_mode,
        input  clk_out, tick
    );

    // Generator side
    modport slave (
        input  en, sync, cfg_we, cfg_ch, cfg_div, cfg_mode,
        output clk_out, tick
    );
endinterface

// File: rtl/clk_div_multi.sv
// NCH independent runtime-programmable dividers; each channel produces either a
// square wave (toggle mode) or a one-cycle strobe (pulse mode) plus a terminal-count tick.
module clk_div_multi #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned W        = 27,
    parameter int unsigned DIV_INIT = 50_000_000,
    parameter int unsigned CHW      = 2
) (
    input  logic          clk,
    input  logic          RESET,
    clk_div_multi_if.slave bus
);

    localparam int unsigned CTR_W = W;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CTR_W-1:0] ctr_q;
        logic [CTR_W-1:0] div_q;
        logic             mode_q;
        logic             out_q;
        logic             tick_q;
        logic             wr_hit_c;
        logic             active_c;
        logic             term_c;

        // A write addressed past the last channel matches no channel and is dropped
        assign wr_hit_c = bus.cfg_we && (bus.cfg_ch == CHW'(g));
        assign active_c = bus.en[g] && (div_q != '0);
        assign term_c   = (ctr_q == (div_q - CTR_W'(1)));

        // Channel state: write/sync restart, hold when inactive, else count to div-1
        always_ff @(posedge clk or posedge RESET) begin
            if (RESET) begin
                ctr_q  <= '0;
                div_q  <= CTR_W'(DIV_INIT);
                mode_q <= 1'b0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (wr_hit_c) begin
                div_q  <= bus.cfg_div;
                mode_q <= bus.cfg_mode;
                ctr_q  <= '0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (bus.sync) begin
                ctr_q  <= '0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (!active_c) begin
                tick_q <= 1'b0;
                if (mode_q) begin
                    out_q <= 1'b0;
                end
            end else if (term_c) begin
                ctr_q  <= '0;
                tick_q <= 1'b1;
                out_q  <= mode_q ? 1'b1 : ~out_q;
            end else begin
                ctr_q  <= ctr_q + CTR_W'(1);
                tick_q <= 1'b0;
                if (mode_q) begin
                    out_q <= 1'b0;
                end
            end
        end

        assign bus.clk_out[g] = out_q;
        assign bus.tick[g]    = tick_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench: stimulus pushes per-edge expectations from an arithmetic
// reference model; an independent monitor pops and compares after each edge.
module tb_clk_div_multi;

    localparam int unsigned NCH      = 3;
    localparam int unsigned W        = 27;
    localparam int unsigned CHW      = 2;
    localparam int unsigned DIV_INIT = 10;

    typedef struct packed {
        logic [NCH-1:0] out;
        logic [NCH-1:0] tick;
    } exp_t;

    logic clk;
    logic RESET;

    clk_div_multi_if #(.NCH(NCH), .W(W), .CHW(CHW)) bus ();

    clk_div_multi #(.NCH(NCH), .W(W), .DIV_INIT(DIV_INIT), .CHW(CHW)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cyc = 0;

    // Reference model: a channel's output is a function of how many enabled
    // counting edges it has seen since its last restart.
    longint m_cnt  [NCH];
    longint m_div  [NCH];
    bit     m_mode [NCH];
    bit     m_out  [NCH];
    bit     m_tick [NCH];

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i]  = 0;
            m_div[i]  = DIV_INIT;
            m_mode[i] = 1'b0;
            m_out[i]  = 1'b0;
            m_tick[i] = 1'b0;
        end
    endfunction

    function automatic void model_step(input logic [NCH-1:0] e, input logic s,
                                       input logic we, input int ch,
                                       input longint d, input logic m);
        for (int i = 0; i < NCH; i++) begin
            if (we && ch == i) begin
                m_div[i]  = d;
                m_mode[i] = m;
                m_cnt[i]  = 0;
                m_out[i]  = 1'b0;
                m_tick[i] = 1'b0;
            end else if (s) begin
                m_cnt[i]  = 0;
                m_out[i]  = 1'b0;
                m_tick[i] = 1'b0;
            end else if (!e[i] || m_div[i] == 0) begin
                m_tick[i] = 1'b0;
                if (m_mode[i]) m_out[i] = 1'b0;
            end else begin
                m_cnt[i]  = m_cnt[i] + 1;
                m_tick[i] = (m_cnt[i] % m_div[i]) == 0;
                m_out[i]  = m_mode[i] ? m_tick[i] : (((m_cnt[i] / m_div[i]) % 2) == 1);
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t x;
        for (int i = 0; i < NCH; i++) begin
            x.out[i]  = m_out[i];
            x.tick[i] = m_tick[i];
        end
        sb_q.push_back(x);
    endfunction

    // One clock of stimulus, applied at the falling edge
    task automatic cycle(input logic [NCH-1:0] e, input logic s, input logic we,
                         input logic [CHW-1:0] ch, input logic [W-1:0] d, input logic m);
        @(negedge clk);
        bus.en       = e;
        bus.sync     = s;
        bus.cfg_we   = we;
        bus.cfg_ch   = ch;
        bus.cfg_div  = d;
        bus.cfg_mode = m;
        model_step(e, s, we, int'(ch), longint'(d), m);
        push_exp();
        n_cyc++;
    endtask

    task automatic run(input int n, input logic [NCH-1:0] e);
        for (int k = 0; k < n; k++) cycle(e, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wr(input int ch, input longint d, input logic m, input logic [NCH-1:0] e);
        cycle(e, 1'b0, 1'b1, CHW'(ch), W'(d), m);
    endtask

    // Reset asserted between edges must clear outputs before the next edge
    task automatic async_reset();
        @(negedge clk);
        #2 RESET = 1'b1;
        #1;
        n_vec++;
        if (bus.clk_out !== '0 || bus.tick !== '0) begin
            n_err++;
            $display("FAIL async_reset: clk_out=%b tick=%b, expected all zero", bus.clk_out, bus.tick);
        end
        model_reset();
        push_exp();
        @(posedge clk);
        #2 RESET = 1'b0;
    endtask

    // Monitor: compare outputs against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_vec++;
                if (bus.clk_out !== e.out || bus.tick !== e.tick) begin
                    n_err++;
                    $display("FAIL edge t=%0t: clk_out=%b tick=%b, expected clk_out=%b tick=%b",
                             $time, bus.clk_out, bus.tick, e.out, e.tick);
                end
            end
        end
    end

    localparam logic [NCH-1:0] ALL = '1;
    localparam longint DMAX = (longint'(1) << W) - 1;

    initial begin
        logic [NCH-1:0] e;
        RESET        = 1'b1;
        bus.en       = '0;
        bus.sync     = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = '0;
        bus.cfg_div  = '0;
        bus.cfg_mode = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        RESET = 1'b0;
        n_vec++;
        if (bus.clk_out !== '0 || bus.tick !== '0) begin
            n_err++;
            $display("FAIL reset_state: clk_out=%b tick=%b, expected all zero", bus.clk_out, bus.tick);
        end

        // Reset divisor on every channel
        run(25, ALL);
        // Toggle channel with div=4
        wr(1, 4, 1'b0, ALL);
        run(16, ALL);
        // Pulse channel div=3, then div=0 (idle), then div=1 (always ticking)
        wr(2, 3, 1'b1, ALL);
        run(9, ALL);
        wr(2, 0, 1'b1, ALL);
        run(5, ALL);
        wr(2, 1, 1'b1, ALL);
        run(5, ALL);
        wr(2, 1, 1'b0, ALL);
        run(5, ALL);
        // Rewrite mid-count: old terminal count must not fire
        wr(1, 4, 1'b0, ALL);
        run(2, ALL);
        wr(1, 6, 1'b0, ALL);
        run(8, ALL);
        // Sync realigns channels, and wins over a coincident terminal count
        wr(0, 5, 1'b0, ALL);
        run(3, ALL);
        wr(1, 10, 1'b0, ALL);
        run(7, ALL);
        cycle(ALL, 1'b1, 1'b0, '0, '0, 1'b0);
        run(12, ALL);
        run(4, ALL);
        cycle(ALL, 1'b1, 1'b0, '0, '0, 1'b0);
        run(6, ALL);
        // Sync together with a write to the same channel
        cycle(ALL, 1'b1, 1'b1, CHW'(2), W'(2), 1'b1);
        run(6, ALL);
        // Enable drop freezes phase, re-enable resumes
        wr(1, 4, 1'b0, ALL);
        run(2, ALL);
        run(7, 3'b101);
        run(5, ALL);
        // Write to a non-existent channel is ignored
        wr(3, 2, 1'b1, ALL);
        run(6, ALL);
        // Largest divisor: no tick within a short window
        wr(0, DMAX, 1'b0, ALL);
        run(6, ALL);
        // Mid-count asynchronous reset restores DIV_INIT
        async_reset();
        run(22, ALL);

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end else begin
                e = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : ALL;
                cycle(e,
                      ($urandom_range(0, 39) == 0),
                      ($urandom_range(0, 14) == 0),
                      CHW'($urandom_range(0, 3)),
                      W'($urandom_range(0, 12)),
                      1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(posedge clk);
        #3;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel, runtime-programmable clock/tick generator driven from the 100 MHz board clock.
- Replaces fixed-divisor dividers (1 Hz, 500 Hz display scan) with NCH independent channels.
- Each channel has its own divisor, enable and output mode: toggle (square wave) or pulse (one-cycle strobe).
- Feeds the display scan, the tempo/beat timer and the note timers; a global sync input phase-aligns all channels.

Parameters:
- NCH, 4, number of channels (1..16).
- W, 27, divisor/counter width in bits.
- DIV_INIT, 50_000_000, reset divisor loaded into every channel (must fit in W bits).
- CHW, 2, width of cfg_ch; must be >= 1 and >= clog2(NCH).

Ports:
- clk  in  1  system clock, 100 MHz.
- RESET  in  1  asynchronous, active-high reset.
- en  in  NCH  per-channel count enable.
- sync  in  1  one-cycle strobe; restarts all channels in phase.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  CHW  channel index for the write.
- cfg_div  in  W  new divisor (cycles per half-period in toggle mode, per period in pulse mode).
- cfg_mode  in  1  0 = toggle, 1 = pulse.
- clk_out  out  NCH  per-channel divided output.
- tick  out  NCH  per-channel one-cycle strobe at each terminal count.

Behaviour:
- Per-channel registers: ctr[W], div[W], mode, out, tick. All are registered; there is no combinational path from inputs to outputs.
- Async RESET: ctr=0, div=DIV_INIT, mode=0, clk_out=0, tick=0 for every channel. Reset takes effect immediately, including mid-count.
- Priority per channel, evaluated each clk edge: RESET > cfg write to this channel / sync > disabled > counting.
- cfg write (cfg_we=1, cfg_ch=i, i<NCH):
  - div<=cfg_div, mode<=cfg_mode, ctr<=0, out<=0, tick<=0.
  - Counting resumes on the next edge using the new values.
  - A write with cfg_ch>=NCH is ignored.
- sync=1: every channel gets ctr<=0, out<=0, tick<=0; div and mode are kept.
  - If sync and a cfg write occur together, both apply to the written channel.
- Channel inactive (en[i]=0 or div==0):
  - ctr holds and tick=0.
  - Toggle mode: out holds. Pulse mode: out=0.
- Counting (en[i]=1, div>=1):
  - If ctr==div-1: ctr<=0, tick<=1. Toggle mode: out<=~out. Pulse mode: out<=1.
  - Otherwise: ctr<=ctr+1, tick<=0. Pulse mode also sets out<=0.
- Timing:
  - tick period = div cycles; tick is high for exactly one cycle.
  - Toggle-mode clk_out period = 2*div cycles, 50% duty.
  - First tick appears div edges after counting starts from ctr=0.
- Boundary cases:
  - div=1: tick is constantly high. Toggle output = clk/2. Pulse output is held at 1.
  - div=2^W-1: ctr reaches 2^W-2 then wraps to 0; no overflow.
- A terminal count coinciding with a cfg write or sync produces no tick on that edge (write/sync wins).
- Deasserting en mid-count freezes phase; reasserting it resumes from the held ctr.
- Channels are fully independent, except for the shared sync input.

Test Plan:
1. Hold RESET for 3 cycles, then release → all clk_out=0, tick=0; with en=all-ones, channel 0 (DIV_INIT overridden to 10 for simulation) ticks after 10 cycles and every 10 cycles thereafter.
2. Write ch1: div=4, mode=0; en[1]=1 → tick[1] high on cycles 4, 8, 12…; clk_out[1] toggles on each tick (period 8, 4 high / 4 low).
3. Write ch2: div=3, mode=1 → clk_out[2] equals tick[2], one-cycle high every 3 cycles. Write div=0 → both stay 0 and ctr holds. Write div=1 → tick constantly high.
4. Ch1 counting at ctr=2 with div=4; write div=6 → ctr cleared and clk_out[1]=0; next tick occurs 6 cycles after the write; no stale tick at the old terminal count.
5. Ch0 div=5, ch1 div=10, running out of phase; pulse sync → both restart from 0 with out=0; tick[0] on cycles 5, 10; tick[1] on cycle 10, coincident with the second tick[0]. Also: sync on the same edge as a terminal count → no tick emitted.
6. Drop en[1] at ctr=2 for 7 cycles → clk_out[1] holds, no tick; re-enable → tick 2 cycles later. Assert RESET asynchronously between clock edges mid-count → outputs clear immediately without waiting for a clk edge; div returns to DIV_INIT.
